// File: rtl/rs_ff_driver.sv
// rs_ff_driver
// Writes a masked target word into a bank of WIDTH rs_ff cells.
// The driver works out the smallest set of set/clear pulses from the live q
// feedback and drives them for PULSE_CYC cycles. It then waits one cycle for
// the bank to update and checks the masked result. If the check fails it
// recomputes and drives again, up to MAX_RETRY more times.
// Because every r/s pulse comes from this block, clients never create the
// forbidden r=s=1 themselves.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   req_valid   request present
//   req_ready   request can be accepted (IDLE only, low during reset)
//   req_target  desired q value per cell
//   req_mask    1 = cell under control, 0 = leave untouched
//   q_fb        q outputs of the RS bank
//   r / s       reset / set pulses to the bank
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   err         one-cycle failure flag, coincident with done
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// CMP    | compute set/clear vectors from the live q_fb
// DRIVE  | hold r/s for PULSE_CYC cycles
// SETTLE | r=s=0, the bank updates q
// VERIFY | compare the masked q_fb with the masked target, retry or finish
// DONE   | done pulse, err as latched

module rs_ff_driver #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int CW = (PULSE_CYC < 1) ? 1 : $clog2(PULSE_CYC + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMP,
    ST_DRIVE,
    ST_SETTLE,
    ST_VERIFY,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_set;
  logic [WIDTH-1:0] r_clr;
  logic [RW-1:0]    r_retry_cnt;
  logic [CW-1:0]    r_pulse_cnt;
  logic             r_err;

  logic [WIDTH-1:0] w_set_v;
  logic [WIDTH-1:0] w_clr_v;
  logic             w_match;
  logic             w_xfer;
  logic             w_pulse_last;

  // The mask is applied to both vectors, so bits outside the mask never pulse.
  // The target bit decides set or clear, so set and clear never overlap.
  assign w_set_v      = r_mask & r_target & ~q_fb;
  assign w_clr_v      = r_mask & ~r_target & q_fb;
  assign w_match      = ((q_fb ^ r_target) & r_mask) == '0;
  assign w_xfer       = req_valid & req_ready;
  assign w_pulse_last = (r_pulse_cnt == CW'(1));

  assign req_ready = rst_n & (r_state == ST_IDLE);
  assign busy      = rst_n & (r_state != ST_IDLE);
  assign done      = rst_n & (r_state == ST_DONE);
  assign err       = done & r_err;
  assign r         = r_clr;
  assign s         = r_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer) w_next = ST_CMP;
      ST_CMP:    w_next = ((w_set_v | w_clr_v) == '0) ? ST_DONE : ST_DRIVE;
      ST_DRIVE:  if (w_pulse_last) w_next = ST_SETTLE;
      ST_SETTLE: w_next = ST_VERIFY;
      ST_VERIFY: w_next = (w_match || (r_retry_cnt == RETRY_LAST)) ? ST_DONE : ST_CMP;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // r/s are registered when CMP exits. They are cleared on the edge that
  // leaves DRIVE, so the bank sees them for exactly PULSE_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target    <= '0;
      r_mask      <= '0;
      r_set       <= '0;
      r_clr       <= '0;
      r_retry_cnt <= '0;
      r_pulse_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_target    <= req_target;
            r_mask      <= req_mask;
            r_retry_cnt <= '0;
            r_err       <= 1'b0;
          end
        end
        ST_CMP: begin
          if (w_next == ST_DRIVE) begin
            r_set       <= w_set_v;
            r_clr       <= w_clr_v;
            r_pulse_cnt <= PULSE_LOAD;
          end
        end
        ST_DRIVE: begin
          if (w_pulse_last) begin
            r_set <= '0;
            r_clr <= '0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - CW'(1);
          end
        end
        ST_VERIFY: begin
          if (!w_match) begin
            if (r_retry_cnt == RETRY_LAST) begin
              r_err <= 1'b1;
            end else begin
              r_retry_cnt <= r_retry_cnt + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_ff_driver.sv
module tb_rs_ff_driver;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: PULSE_CYC=1, MAX_RETRY=2
  logic         rst_n, req_valid, req_ready, busy, done, err;
  logic [W-1:0] req_target, req_mask, q_fb, r, s;
  logic [W-1:0] bank, bank_init, stuck_lo;
  logic         bank_load;

  // DUT 2: PULSE_CYC=4, used for reset in the middle of DRIVE
  logic         rst2_n, valid2, ready2, busy2, done2, err2;
  logic [W-1:0] target2, mask2, q2, r2, s2, bank2, bank2_init;
  logic         bank2_load;

  rs_ff_driver #(.WIDTH(W), .PULSE_CYC(1), .MAX_RETRY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_mask(req_mask), .q_fb(q_fb),
    .r(r), .s(s), .busy(busy), .done(done), .err(err)
  );

  rs_ff_driver #(.WIDTH(W), .PULSE_CYC(4), .MAX_RETRY(2)) u_dut4 (
    .clk(clk), .rst_n(rst2_n), .req_valid(valid2), .req_ready(ready2),
    .req_target(target2), .req_mask(mask2), .q_fb(q2),
    .r(r2), .s(s2), .busy(busy2), .done(done2), .err(err2)
  );

  // RS bank models: set wins over reset, and stuck-low cells never rise.
  always @(posedge clk) begin
    if (bank_load) bank <= bank_init & ~stuck_lo;
    else           bank <= ((bank & ~r) | s) & ~stuck_lo;
    if (bank2_load) bank2 <= bank2_init;
    else            bank2 <= (bank2 & ~r2) | s2;
  end
  assign q_fb = bank;
  assign q2   = bank2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int           cyc_done, rs_cyc, first_rs;
  logic         err_at_done, overlap, bad_mask, ready_seen, err_alone;
  logic [W-1:0] s_seen, r_seen;

  task automatic load_bank(input logic [W-1:0] v);
    bank_init = v;
    bank_load = 1'b1;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Call at a negedge with DUT 1 idle. The task returns at the negedge of the done cycle.
  task automatic run_req(input logic [W-1:0] t, input logic [W-1:0] m);
    req_valid = 1'b1; req_target = t; req_mask = m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_target = ~t; req_mask = ~m;
    cyc_done = 0; rs_cyc = 0; first_rs = 0; err_at_done = 1'b0;
    overlap = 1'b0; bad_mask = 1'b0; ready_seen = 1'b0; err_alone = 1'b0;
    s_seen = '0; r_seen = '0;
    for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
      if ((r & s) != '0) overlap = 1'b1;
      if (((r | s) & ~m) != '0) bad_mask = 1'b1;
      if ((r | s) != '0) begin
        rs_cyc++;
        if (first_rs == 0) first_rs = c;
      end
      s_seen |= s; r_seen |= r;
      if (req_ready) ready_seen = 1'b1;
      if (err && !done) err_alone = 1'b1;
      if (done) begin
        cyc_done = c; err_at_done = err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_target = '0; req_mask = '0;
    bank_load = 1'b0; bank_init = '0; stuck_lo = '0; bank = '0;
    rst2_n = 1'b0; valid2 = 1'b0; target2 = '0; mask2 = '0;
    bank2_load = 1'b0; bank2_init = '0; bank2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_rs", {r, s}, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);

    // Set bits
    load_bank(8'h00);
    run_req(8'h0F, 8'hFF);
    check("set_done_cyc", cyc_done, 5);
    check("set_err", err_at_done, 0);
    check("set_s", s_seen, 8'h0F);
    check("set_r", r_seen, 8'h00);
    check("set_pulse_len", rs_cyc, 1);
    check("set_pulse_cyc", first_rs, 2);
    check("set_q", q_fb, 8'h0F);
    check("set_ready_busy", ready_seen, 0);
    @(negedge clk);
    check("set_ready_after", req_ready, 1);
    check("set_busy_after", busy, 0);

    // Mixed set/clear
    load_bank(8'hA5);
    run_req(8'h5A, 8'hFF);
    check("mix_done_cyc", cyc_done, 5);
    check("mix_err", err_at_done, 0);
    check("mix_s", s_seen, 8'h5A);
    check("mix_r", r_seen, 8'hA5);
    check("mix_overlap", overlap, 0);
    check("mix_q", q_fb, 8'h5A);
    @(negedge clk);

    // Masked no-op
    load_bank(8'h3C);
    run_req(8'hFF, 8'h3C);
    check("noop_done_cyc", cyc_done, 2);
    check("noop_err", err_at_done, 0);
    check("noop_rs_cycles", rs_cyc, 0);
    check("noop_q", q_fb, 8'h3C);
    @(negedge clk);

    // M=0
    run_req(8'h00, 8'h00);
    check("m0_done_cyc", cyc_done, 2);
    check("m0_err", err_at_done, 0);
    check("m0_rs_cycles", rs_cyc, 0);
    @(negedge clk);

    // Partial mask with changes: only the low nibble may move
    load_bank(8'h00);
    run_req(8'hFF, 8'h0F);
    check("pmask_done_cyc", cyc_done, 5);
    check("pmask_s", s_seen, 8'h0F);
    check("pmask_outside", bad_mask, 0);
    check("pmask_q", q_fb, 8'h0F);
    @(negedge clk);

    // Stuck cell: three attempts, then done and err together
    stuck_lo = 8'h04;
    load_bank(8'h00);
    run_req(8'h04, 8'h04);
    check("stuck_done_cyc", cyc_done, 13);
    check("stuck_err", err_at_done, 1);
    check("stuck_pulses", rs_cyc, 3);
    check("stuck_s", s_seen, 8'h04);
    check("stuck_err_alone", err_alone, 0);
    @(negedge clk);
    check("stuck_ready_after", req_ready, 1);
    check("stuck_err_after", err, 0);
    stuck_lo = 8'h00;

    // Back-pressure: valid stays high and data changes while busy
    load_bank(8'h00);
    req_valid = 1'b1; req_target = 8'h01; req_mask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("hs_ready_c1", req_ready, 0);
    req_target = 8'h80;
    cyc_done = 0; ready_seen = 1'b0;
    for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
      if (req_ready) ready_seen = 1'b1;
      if (done) cyc_done = c;
      else @(negedge clk);
    end
    check("hs_done_cyc", cyc_done, 5);
    check("hs_ready_busy", ready_seen, 0);
    check("hs_first_word", q_fb, 8'h01);
    @(negedge clk);
    check("hs_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("hs_second_busy", busy, 1);
    cyc_done = 0;
    for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
      if (done) cyc_done = c;
      else @(negedge clk);
    end
    check("hs2_done_cyc", cyc_done, 5);
    check("hs2_q", q_fb, 8'h80);
    @(negedge clk);

    // Reset in the middle of DRIVE on the PULSE_CYC=4 instance
    bank2_init = 8'h00; bank2_load = 1'b1;
    @(negedge clk);
    bank2_load = 1'b0;
    valid2 = 1'b1; target2 = 8'hFF; mask2 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("p4_s_in_drive", s2, 8'hFF);
    rst2_n = 1'b0;
    @(negedge clk);
    check("p4_rst_rs", {r2, s2}, 0);
    check("p4_rst_busy", busy2, 0);
    check("p4_rst_ready", ready2, 0);
    rst2_n = 1'b1;
    ready_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done2 || err2) ready_seen = 1'b1;
      @(negedge clk);
    end
    check("p4_no_done", ready_seen, 0);
    check("p4_idle", ready2, 1);
    valid2 = 1'b1; target2 = 8'h00; mask2 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    cyc_done = 0; rs_cyc = 0; err_at_done = 1'b0;
    for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
      if ((r2 | s2) != '0) rs_cyc++;
      if (done2) begin
        cyc_done = c; err_at_done = err2;
      end else begin
        @(negedge clk);
      end
    end
    check("p4_done_cyc", cyc_done, 8);
    check("p4_err", err_at_done, 0);
    check("p4_pulse_len", rs_cyc, 4);
    check("p4_q", q2, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_ff_driver.md
Name: rs_ff_driver

Overview:
- Command-side driver for a bank of WIDTH rs_ff cells. It is the writer that produces the r/s excitation those cells consume.
- Accepts a masked target word over a valid/ready handshake. Computes the minimal set/clear pulses against the live q feedback, drives them, then verifies the bank.
- Retries a bounded number of times and reports done/err.
- Sits between control logic and the RS state-register bank, so no client ever generates r/s pulses, including the forbidden r=s=1, by hand.

Parameters:
- WIDTH, 8: number of RS cells driven; width of target, mask, r, s, q_fb.
- PULSE_CYC, 1: cycles each r/s pulse is held (>=1).
- MAX_RETRY, 2: extra drive attempts after a failed verify; total attempts = MAX_RETRY+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  driver can accept; high only in IDLE.
- req_target  input  WIDTH  desired q value per cell.
- req_mask  input  WIDTH  1 = cell is under control; 0 = leave untouched.
- q_fb  input  WIDTH  q outputs of the RS bank.
- r  output  WIDTH  reset pulses to the bank.
- s  output  WIDTH  set pulses to the bank.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle failure flag, coincident with done.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; r=s=0; done=err=0; retry_cnt=0; captured target/mask=0. req_ready=0 and busy=0 while rst_n is low.
- Handshake: transfer on posedge with req_valid & req_ready. The cycle after that edge is cycle 1. The block captures req_target (T) and req_mask (M) at the transfer edge. Input changes after capture are ignored.
- States: IDLE, CMP, DRIVE, SETTLE, VERIFY, DONE.
- IDLE: req_ready=1; go to CMP on transfer; clear retry_cnt.
- CMP (1 cycle):
  - set_v = M & T & ~q_fb
  - clr_v = M & ~T & q_fb
  - If both are zero, go to DONE. Otherwise register s<=set_v, r<=clr_v and go to DRIVE.
- DRIVE: hold r/s for exactly PULSE_CYC cycles using a pulse counter, then go to SETTLE.
- SETTLE (1 cycle): r=s=0, giving the bank time to update q.
- VERIFY (1 cycle): compare (q_fb & M) with (T & M).
  - Match: go to DONE with err=0.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt++ and go to CMP (recompute from live q_fb).
  - Mismatch and retry_cnt==MAX_RETRY: go to DONE with err=1.
- DONE (1 cycle): done=1, err as latched; next state IDLE. A new request is accepted no earlier than the cycle after DONE.
- Latency, PULSE_CYC=P:
  - Changes needed, success on first pass: done asserted in cycle 4+P (P=1: cycle 5).
  - No change needed: done in cycle 2; r/s never asserted.
- Invariants:
  - (r & s)==0 on every cycle.
  - r[i]=s[i]=0 whenever M[i]=0.
  - r=s=0 in all states except DRIVE.
  - done and err never assert outside DONE.
- Width rules: all vector operations are bitwise at WIDTH. retry_cnt is sized clog2(MAX_RETRY+1), minimum 1 bit. The pulse counter is sized clog2(PULSE_CYC+1).
- Reset mid-operation: the next posedge with rst_n=0 forces IDLE and r=s=0 immediately. No done is emitted; the in-flight request is dropped.
- M=0: treated as the no-change case; done in cycle 2, err=0.
- q_fb changing between VERIFY and the next CMP: CMP always uses the live value.

Test Plan:
- Set bits: q_fb=8'h00, T=8'h0F, M=8'hFF, P=1, bank model attached -> s=8'h0F, r=0 for exactly cycle 2; q_fb=8'h0F by VERIFY; done=1, err=0 in cycle 5.
- Mixed set/clear: q_fb=8'hA5, T=8'h5A, M=8'hFF -> s=8'h5A, r=8'hA5, r&s=0; done in cycle 5, err=0.
- Mask and no-op: q_fb=8'h3C, T=8'hFF, M=8'h3C -> r=s=0 throughout; done in cycle 2, err=0.
- Stuck cell: bank bit 2 forced to 0, q_fb=0, T=8'h04, M=8'h04, MAX_RETRY=2 -> three s=8'h04 pulses; done=1 and err=1 together; then req_ready=1.
- Reset mid-DRIVE: PULSE_CYC=4, rst_n=0 for one cycle during DRIVE -> r=s=0 at that edge; busy=0; no done/err; next request completes normally.
- Handshake back-pressure: req_valid held high with changing data during busy -> only the first word is captured; req_ready=0 until IDLE; second word is accepted the cycle after done.
